// File: rtl/jtpopeye_ps2_keyev.sv
// PS/2 keyboard receiver producing the 11-bit ps2_key event word.
// Raw pins are synchronised and debounced, frames are validated (start,
// 8 data LSB first, odd parity, stop), E0/F0 prefixes are folded, and
// each real key event is emitted as {toggle, pressed, extended, code}.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ps2_clk   raw PS/2 clock pin (idle high)
//   ps2_data  raw PS/2 data pin (idle high)
//   ps2_key   [10] toggle, [9] make, [8] E0-extended, [7:0] scan code
//   key_stb   one-cycle pulse when ps2_key changes
//   err       one-cycle pulse on framing, parity or timeout error

// Per-pin conditioner: 2-FF synchroniser followed by a level filter that
// only accepts a new level after FILT consecutive synced samples at it.
module jtpopeye_ps2_keyev_filt #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl
);
  localparam int FCW = $clog2(FILT + 1);

  logic           s1, s2;
  logic [FCW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == FCW'(FILT - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module jtpopeye_ps2_keyev #(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 40000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_stb,
  output logic        err
);
  localparam int NUM_PINS = 2;
  localparam int TOW      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_t;

  // pin conditioning: index 0 = clock, 1 = data
  logic [NUM_PINS-1:0] pins, lvl;
  assign pins = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      jtpopeye_ps2_keyev_filt #(.FILT(FILT)) u_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (pins[gi]),
        .lvl   (lvl[gi])
      );
    end
  endgenerate

  logic fclk_q, fall, sdat;
  assign fall = fclk_q & ~lvl[0];
  assign sdat = lvl[1];

  st_t            st, st_nx;
  logic [2:0]     bcnt;
  logic [7:0]     sbyte;
  logic           par;
  logic [TOW-1:0] to_cnt;
  logic           ext, rel;
  logic           deliver, err_nx, clr;

  // Frame FSM. A sampling event is checked before the timeout so that a
  // coincident edge keeps the frame alive.
  always_comb begin
    st_nx   = st;
    deliver = 1'b0;
    err_nx  = 1'b0;
    clr     = 1'b0;
    if (fall) begin
      case (st)
        IDLE:   if (!sdat) st_nx = DATA; else err_nx = 1'b1;
        DATA:   if (bcnt == 3'd7) st_nx = PARITY;
        PARITY: st_nx = STOP;
        STOP: begin
          st_nx = IDLE;
          if (sdat && ^{sbyte, par}) begin
            deliver = 1'b1;
          end else begin
            err_nx = 1'b1;
            clr    = 1'b1;
          end
        end
        default: st_nx = IDLE;
      endcase
    end else if (st != IDLE && to_cnt == TOW'(TIMEOUT)) begin
      st_nx  = IDLE;
      err_nx = 1'b1;
      clr    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      fclk_q <= 1'b1;
      bcnt   <= '0;
      sbyte  <= '0;
      par    <= 1'b0;
      to_cnt <= '0;
    end else begin
      st     <= st_nx;
      fclk_q <= lvl[0];
      if (st != DATA)
        bcnt <= '0;
      else if (fall) begin
        bcnt        <= bcnt + 3'd1;
        sbyte[bcnt] <= sdat;
      end
      if (fall && st == PARITY) par <= sdat;
      // saturating inter-edge watchdog, idle while no frame is open
      if (fall || st == IDLE)
        to_cnt <= '0;
      else if (to_cnt != TOW'(TIMEOUT))
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // Byte layer: prefixes latch ext/rel, housekeeping codes are dropped,
  // everything else becomes an event and consumes the prefixes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_key <= '0;
      key_stb <= 1'b0;
      err     <= 1'b0;
      ext     <= 1'b0;
      rel     <= 1'b0;
    end else begin
      key_stb <= 1'b0;
      err     <= err_nx;
      if (clr) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (deliver) begin
        case (sbyte)
          8'hE0: ext <= 1'b1;
          8'hF0: rel <= 1'b1;
          8'h00, 8'hAA, 8'hE1, 8'hEE,
          8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
          default: begin
            ps2_key <= {~ps2_key[10], ~rel, ext, sbyte};
            key_stb <= 1'b1;
            ext     <= 1'b0;
            rel     <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtpopeye_ps2_keyev.sv
module tb_jtpopeye_ps2_keyev;
  localparam int FILT    = 8;
  localparam int TIMEOUT = 400;
  localparam int HALF    = 40;       // PS/2 half bit period in clk cycles
  localparam int LAT     = FILT + 3; // pin fall -> key_stb observed

  logic        clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_stb, err;

  jtpopeye_ps2_keyev #(.FILT(FILT), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .key_stb  (key_stb),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] key;
    int          lat;
  } got_t;

  typedef struct {
    logic [7:0] code;
    logic       good;
    logic       evt;
    logic [9:0] low;
  } vec_t;

  int          cyc = 0, stop_cyc = 0, err_seen = 0, both_hi = 0;
  int          n_chk = 0, n_fail = 0, exp_err = 0;
  logic        m_tog = 1'b0;
  got_t        got_q[$];
  logic [10:0] exp_q[$];
  vec_t        tbl[16];

  always @(posedge clk) cyc++;

  // record what the DUT produces; comparison happens in the main thread
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_stb) got_q.push_back('{ps2_key, cyc - stop_cyc});
      if (err) err_seen++;
      if (key_stb && err) both_hi++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_data = b[i];
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b0;
      stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] code, input logic good);
    logic p;
    p = good ? ~^code : ^code;
    return {1'b1, p, code, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] code, input logic good);
    send_bits(frame(code, good), 11);
    repeat (20) @(negedge clk);
  endtask

  task automatic expect_evt(input logic [9:0] low);
    m_tog = ~m_tog;
    exp_q.push_back({m_tog, low});
  endtask

  task automatic drain(input string name);
    got_t g;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s_spurious: got event 0x%0h expected none", name, g.key);
      end else begin
        chk({name, "_key"}, int'(g.key), int'(exp_q.pop_front()));
        chk({name, "_lat"}, g.lat, LAT);
      end
    end
    chk({name, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
    chk({name, "_err"}, err_seen, exp_err);
    chk({name, "_both"}, both_hi, 0);
  endtask

  initial begin
    tbl[0]  = '{8'h1C, 1'b1, 1'b1, 10'h21C};
    tbl[1]  = '{8'hE0, 1'b1, 1'b0, 10'h000};
    tbl[2]  = '{8'hF0, 1'b1, 1'b0, 10'h000};
    tbl[3]  = '{8'h75, 1'b1, 1'b1, 10'h175};
    tbl[4]  = '{8'h14, 1'b1, 1'b1, 10'h214};
    tbl[5]  = '{8'h29, 1'b0, 1'b0, 10'h000};
    tbl[6]  = '{8'h29, 1'b1, 1'b1, 10'h229};
    tbl[7]  = '{8'hF0, 1'b1, 1'b0, 10'h000};
    tbl[8]  = '{8'hAA, 1'b1, 1'b0, 10'h000};
    tbl[9]  = '{8'h1C, 1'b1, 1'b1, 10'h01C};
    tbl[10] = '{8'hE0, 1'b1, 1'b0, 10'h000};
    tbl[11] = '{8'h29, 1'b0, 1'b0, 10'h000};
    tbl[12] = '{8'h6B, 1'b1, 1'b1, 10'h26B};
    tbl[13] = '{8'hE0, 1'b1, 1'b0, 10'h000};
    tbl[14] = '{8'hE1, 1'b1, 1'b0, 10'h000};
    tbl[15] = '{8'h5A, 1'b1, 1'b1, 10'h35A};

    repeat (3) @(negedge clk);
    chk("rst_key", int'(ps2_key), 0);
    chk("rst_stb", int'(key_stb), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].evt) expect_evt(tbl[i].low);
      if (!tbl[i].good) exp_err++;
      send_byte(tbl[i].code, tbl[i].good);
      drain($sformatf("vec%0d", i));
    end

    // a clock edge with data high while idle is a bad start bit
    exp_err++;
    send_bits(11'h7FF, 1);
    repeat (20) @(negedge clk);
    drain("idle_start");

    // abort after 4 data bits, then a clean frame must still decode
    exp_err++;
    send_bits(frame(8'h05, 1'b1), 5);
    repeat (TIMEOUT + 100) @(negedge clk);
    drain("timeout");
    expect_evt(10'h205);
    send_byte(8'h05, 1'b1);
    drain("after_to");

    // short clock glitches are filtered out
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    drain("glitch");
    send_byte(8'hFA, 1'b1);
    drain("ack");

    // reset partway through a frame
    send_bits(frame(8'h16, 1'b1), 7);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_key", int'(ps2_key), 0);
    chk("midrst_stb", int'(key_stb), 0);
    chk("midrst_err", int'(err), 0);
    @(negedge clk) rst_n = 1'b1;
    m_tog = 1'b0;
    repeat (5) @(negedge clk);
    expect_evt(10'h216);
    send_byte(8'h16, 1'b1);
    drain("post_rst");
    chk("post_rst_word", int'(ps2_key), 'h616);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
